// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: decode-side control and results plus the instruction-memory read port.
// The master modport is the fetch unit; the slave modport is decode/memory.
interface instr_fetch_unit_if #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 9
);
    logic                   go;
    logic                   halt_in;
    logic                   branch_taken;
    logic [PC_WIDTH-1:0]    branch_target;
    logic                   stall;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [INSTR_WIDTH-1:0] imem_data;
    logic [INSTR_WIDTH-1:0] instruction_out;
    logic [PC_WIDTH-1:0]    pc_out;
    logic                   valid_out;
    logic                   halted;

    modport master (
        input  go, halt_in, branch_taken, branch_target, stall, imem_data,
        output imem_addr, instruction_out, pc_out, valid_out, halted
    );

    modport slave (
        output go, halt_in, branch_taken, branch_target, stall, imem_data,
        input  imem_addr, instruction_out, pc_out, valid_out, halted
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC register, async imem read, registered {instruction, pc}
// to decode, branch redirect with a one-cycle bubble, and IDLE/RUN/HALTED sequencing.
module instr_fetch_unit #(
    parameter int                     PC_WIDTH    = 8,
    parameter int                     INSTR_WIDTH = 9,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 9'h1B0
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_unit_if.master  bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [PC_WIDTH-1:0]    pc_out_q, pc_out_d;
    logic                   valid_q, valid_d;
    logic                   halted_q, halted_d;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        unique case (state_q)
            S_IDLE: begin
                pc_d     = '0;
                instr_d  = NOP_INSTR;
                pc_out_d = '0;
                valid_d  = 1'b0;
                halted_d = 1'b0;
                if (bus.go) state_d = S_RUN;
            end
            S_RUN: begin
                // Halt and branch only act on a real word; a bubble carries no decode result.
                if (bus.halt_in && valid_q) begin
                    state_d  = S_HALTED;
                    valid_d  = 1'b0;
                    instr_d  = NOP_INSTR;
                    halted_d = 1'b1;
                end else if (bus.branch_taken && valid_q) begin
                    pc_d    = bus.branch_target;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end else if (!bus.stall) begin
                    instr_d  = bus.imem_data;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    pc_d     = pc_q + PC_WIDTH'(1);
                end
            end
            S_HALTED: begin
                valid_d  = 1'b0;
                halted_d = 1'b1;
                if (bus.go) begin
                    state_d  = S_RUN;
                    pc_d     = '0;
                    halted_d = 1'b0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                pc_d     = '0;
                instr_d  = NOP_INSTR;
                pc_out_d = '0;
                valid_d  = 1'b0;
                halted_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            instr_q  <= NOP_INSTR;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign bus.imem_addr       = pc_q;
    assign bus.instruction_out = instr_q;
    assign bus.pc_out          = pc_out_q;
    assign bus.valid_out       = valid_q;
    assign bus.halted          = halted_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model of the fetch front end.
module tb_instr_fetch_unit;
    localparam logic [8:0] NOP = 9'h1B0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.PC_WIDTH(8), .INSTR_WIDTH(9)) ifc();
    logic [8:0] mem [0:255];
    assign ifc.imem_data = mem[ifc.imem_addr];

    instr_fetch_unit dut (.clk(clk), .reset(reset), .bus(ifc));

    int vectors = 0;
    int miscompares = 0;

    // Model: mode 0=idle, 1=running, 2=halted.
    int         m_mode;
    logic [7:0] m_pc, m_opc;
    logic [8:0] m_out;
    logic       m_v;

    function automatic logic [26:0] obs();
        return {ifc.halted, ifc.valid_out, ifc.instruction_out, ifc.pc_out, ifc.imem_addr};
    endfunction

    function automatic logic [26:0] expv();
        return {(m_mode == 2), m_v, m_out, m_opc, m_pc};
    endfunction

    task automatic drive(input logic g, input logic h, input logic b, input logic [7:0] t,
                         input logic s);
        ifc.go = g; ifc.halt_in = h; ifc.branch_taken = b; ifc.branch_target = t; ifc.stall = s;
    endtask

    task automatic tick();
        int         n_mode = m_mode;
        logic [7:0] n_pc = m_pc, n_opc = m_opc;
        logic [8:0] n_out = m_out;
        logic       n_v = m_v;
        if (reset) begin
            n_mode = 0; n_pc = 0; n_opc = 0; n_out = NOP; n_v = 0;
        end else if (m_mode == 0) begin
            if (ifc.go) n_mode = 1;
        end else if (m_mode == 2) begin
            if (ifc.go) begin n_mode = 1; n_pc = 0; end
        end else if (ifc.halt_in && m_v) begin
            n_mode = 2; n_v = 0; n_out = NOP;
        end else if (ifc.branch_taken && m_v) begin
            n_pc = ifc.branch_target; n_out = NOP; n_v = 0;
        end else if (!ifc.stall) begin
            n_out = mem[m_pc]; n_opc = m_pc; n_v = 1; n_pc = 8'((int'(m_pc) + 1) % 256);
        end
        @(posedge clk);
        #1;
        m_mode = n_mode; m_pc = n_pc; m_opc = n_opc; m_out = n_out; m_v = n_v;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) mem[i] = 9'($urandom_range(0, 511));
        reset = 1'b1;
        drive(0, 0, 0, 8'h00, 0);
        m_mode = 0; m_pc = 8'hAA; m_opc = 8'h55; m_out = 9'h0; m_v = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        vectors++;
        if (obs() !== {1'b0, 1'b0, NOP, 8'h00, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_values: got %h want %h", obs(), {1'b0, 1'b0, NOP, 8'h00, 8'h00});
        end
        repeat (2) tick();
        vectors++;
        if (obs() !== expv() || ifc.valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_hold: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_run_and_branch();
        logic [8:0] want [3];
        want[0] = 9'h012; want[1] = 9'h01F; want[2] = 9'h024;
        for (int i = 0; i < 3; i++) mem[i] = want[i];
        ifc.go = 1'b1;
        tick();
        ifc.go = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({ifc.valid_out, ifc.instruction_out, ifc.pc_out} !== {1'b1, want[i], 8'(i)}) begin
                miscompares++;
                $display("FAIL run_word%0d: got v=%b %h pc=%h want v=1 %h pc=%h", i,
                         ifc.valid_out, ifc.instruction_out, ifc.pc_out, want[i], 8'(i));
            end
        end
        tick();
        vectors++;
        if (ifc.pc_out !== 8'h03 || obs() !== expv()) begin
            miscompares++;
            $display("FAIL run_pc3: got %h want %h", obs(), expv());
        end
        drive(0, 0, 1, 8'h40, 0);
        tick();
        ifc.branch_taken = 1'b0;
        vectors++;
        if ({ifc.valid_out, ifc.instruction_out} !== {1'b0, NOP} || obs() !== expv()) begin
            miscompares++;
            $display("FAIL branch_bubble: got %h want %h", obs(), expv());
        end
        tick();
        vectors++;
        if ({ifc.valid_out, ifc.instruction_out, ifc.pc_out} !== {1'b1, mem[8'h40], 8'h40}) begin
            miscompares++;
            $display("FAIL branch_target: got %h/%h want %h/40", ifc.instruction_out,
                     ifc.pc_out, mem[8'h40]);
        end
    endtask

    task automatic test_stall();
        logic [8:0] held;
        drive(0, 0, 1, 8'h04, 0);
        tick();
        ifc.branch_taken = 1'b0;
        repeat (2) tick();
        held = ifc.instruction_out;
        vectors++;
        if (ifc.pc_out !== 8'h05 || held !== mem[5]) begin
            miscompares++;
            $display("FAIL stall_pre: got pc=%h %h want pc=05 %h", ifc.pc_out, held, mem[5]);
        end
        ifc.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if ({ifc.valid_out, ifc.instruction_out, ifc.pc_out, ifc.imem_addr} !==
                {1'b1, held, 8'h05, 8'h06}) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got %h want %h", i, obs(), expv());
            end
        end
        ifc.stall = 1'b0;
        tick();
        vectors++;
        if (ifc.pc_out !== 8'h06 || obs() !== expv()) begin
            miscompares++;
            $display("FAIL stall_release: got %h want %h", obs(), expv());
        end
        ifc.stall = 1'b1;
        tick();
        ifc.branch_taken = 1'b1; ifc.branch_target = 8'h20;
        tick();
        drive(0, 0, 0, 8'h00, 0);
        vectors++;
        if (ifc.valid_out !== 1'b0 || ifc.imem_addr !== 8'h20 || obs() !== expv()) begin
            miscompares++;
            $display("FAIL stall_branch: got %h want %h", obs(), expv());
        end
        tick();
        vectors++;
        if ({ifc.valid_out, ifc.pc_out, ifc.instruction_out} !== {1'b1, 8'h20, mem[8'h20]}) begin
            miscompares++;
            $display("FAIL stall_branch_tgt: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_halt();
        mem[7] = 9'h1A0;
        drive(0, 0, 1, 8'h07, 0);
        tick();
        ifc.branch_taken = 1'b0;
        tick();
        ifc.halt_in = 1'b1;
        tick();
        ifc.halt_in = 1'b0;
        vectors++;
        if ({ifc.halted, ifc.valid_out, ifc.imem_addr} !== {1'b1, 1'b0, 8'h08}) begin
            miscompares++;
            $display("FAIL halt_enter: got %h want %h", obs(), expv());
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 1, 8'h33, i[0]);
            tick();
            vectors++;
            if (ifc.imem_addr !== 8'h08 || ifc.halted !== 1'b1 || obs() !== expv()) begin
                miscompares++;
                $display("FAIL halt_hold%0d: got %h want %h", i, obs(), expv());
            end
        end
        drive(1, 0, 0, 8'h00, 0);
        tick();
        ifc.go = 1'b0;
        vectors++;
        if ({ifc.halted, ifc.valid_out, ifc.imem_addr} !== {1'b0, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL halt_restart: got %h want %h", obs(), expv());
        end
        tick();
        vectors++;
        if ({ifc.valid_out, ifc.pc_out, ifc.instruction_out} !== {1'b1, 8'h00, mem[0]}) begin
            miscompares++;
            $display("FAIL restart_word0: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_wrap_reset();
        logic [7:0] want [3];
        want[0] = 8'hFE; want[1] = 8'hFF; want[2] = 8'h00;
        drive(0, 0, 1, 8'hFE, 0);
        tick();
        ifc.branch_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (ifc.pc_out !== want[i] || ifc.valid_out !== 1'b1 || obs() !== expv()) begin
                miscompares++;
                $display("FAIL wrap%0d: got pc=%h want pc=%h", i, ifc.pc_out, want[i]);
            end
        end
        reset = 1'b1;
        ifc.go = 1'b1;
        tick();
        reset = 1'b0;
        ifc.go = 1'b0;
        vectors++;
        if (obs() !== {1'b0, 1'b0, NOP, 8'h00, 8'h00}) begin
            miscompares++;
            $display("FAIL wrap_reset: got %h want %h", obs(), {1'b0, 1'b0, NOP, 8'h00, 8'h00});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 99) < 2);
            drive($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 4,
                  $urandom_range(0, 99) < 15, 8'($urandom_range(0, 255)),
                  $urandom_range(0, 99) < 25);
            tick();
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL random_cyc%0d: got %h want %h", i, obs(), expv());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run_and_branch();
        test_stall();
        test_halt();
        test_wrap_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
